// File: rtl/bash_hash_params_pkg.sv
// Shared parameters and types for the bash_hash sponge datapath and its sequencer.
package bash_hash_params_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned BASH_ROUNDS = 24;

    typedef enum logic [1:0] {
        IDLE,
        WORK,
        DONE
    } bash_ctrl_state_t;

endpackage

// File: rtl/bash_hash_ctrl.sv
// Block sequencer for bash_hash: accepts one request, issues the load strobe,
// steps the datapath through the rounds and holds the result until it is acknowledged.
module bash_hash_ctrl
    import bash_hash_params_pkg::*;
#(
    parameter int unsigned ROUNDS = BASH_ROUNDS,
    parameter int unsigned RW     = $clog2(ROUNDS + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_first_i,
    input  logic            req_clr_i,
    input  logic [XLEN-1:0] req_l_i,
    input  logic            abort_i,
    output logic            prep_o,
    output logic            start_o,
    output logic            work_o,
    output logic            first_o,
    output logic [XLEN-1:0] l_o,
    output logic [RW-1:0]   round_o,
    output logic            busy_o,
    output logic            done_valid_o,
    input  logic            done_ready_i
);

    bash_ctrl_state_t state_q, state_d;
    logic [RW-1:0]    round_q;
    logic             clr_q;
    logic [XLEN-1:0]  l_q;
    logic             fire;
    logic             last_round;

    assign last_round = (round_q == RW'(ROUNDS - 1));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; abort overrides everything and blocks acceptance
    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        fire         = 1'b0;
        start_o      = 1'b0;
        prep_o       = 1'b0;
        work_o       = 1'b0;
        first_o      = 1'b0;
        busy_o       = 1'b0;
        done_valid_o = 1'b0;
        round_o      = '0;
        l_o          = l_q;

        unique case (state_q)
            IDLE: req_ready_o = ~abort_i;
            DONE: req_ready_o = ~abort_i & done_ready_i;
            default: req_ready_o = 1'b0;
        endcase

        fire    = req_valid_i & req_ready_o;
        start_o = fire;
        prep_o  = fire & req_first_i;
        if (fire && req_first_i) begin
            l_o = req_l_i;
        end

        unique case (state_q)
            IDLE: begin
                if (fire) state_d = WORK;
            end
            WORK: begin
                work_o  = 1'b1;
                busy_o  = 1'b1;
                first_o = clr_q;
                round_o = round_q;
                if (last_round) state_d = DONE;
            end
            DONE: begin
                done_valid_o = 1'b1;
                if (done_ready_i) state_d = fire ? WORK : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort_i) state_d = IDLE;
    end

    // Round counter wraps to 0 on the last round so DONE/IDLE always see 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            round_q <= '0;
        end else if (abort_i || fire) begin
            round_q <= '0;
        end else if (state_q == WORK) begin
            round_q <= last_round ? '0 : round_q + RW'(1);
        end
    end

    // Per-message security level and per-block clear flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            l_q   <= '0;
            clr_q <= 1'b0;
        end else if (fire) begin
            clr_q <= req_clr_i;
            if (req_first_i) l_q <= req_l_i;
        end
    end

endmodule

// File: tb/tb_bash_hash_ctrl.sv
// Self-checking bench for bash_hash_ctrl: per-cycle expectations are derived from
// the block timeline (load cycle, 24 round cycles, result hold) and a latched-level model.
module tb_bash_hash_ctrl;
    import bash_hash_params_pkg::*;

    localparam int unsigned NR = 24;
    localparam int unsigned RW = 5;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_first_i;
    logic            req_clr_i;
    logic [XLEN-1:0] req_l_i;
    logic            abort_i;
    logic            prep_o;
    logic            start_o;
    logic            work_o;
    logic            first_o;
    logic [XLEN-1:0] l_o;
    logic [RW-1:0]   round_o;
    logic            busy_o;
    logic            done_valid_o;
    logic            done_ready_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int next_fire_cyc = -1;
    logic [XLEN-1:0] ref_l = '0;

    bash_hash_ctrl #(.ROUNDS(NR), .RW(RW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_first_i  (req_first_i),
        .req_clr_i    (req_clr_i),
        .req_l_i      (req_l_i),
        .abort_i      (abort_i),
        .prep_o       (prep_o),
        .start_o      (start_o),
        .work_o       (work_o),
        .first_o      (first_o),
        .l_o          (l_o),
        .round_o      (round_o),
        .busy_o       (busy_o),
        .done_valid_o (done_valid_o),
        .done_ready_i (done_ready_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // {ready, start, prep, work, first, busy, done_valid}
    function automatic logic [6:0] strobes();
        return {req_ready_o, start_o, prep_o, work_o, first_o, busy_o, done_valid_o};
    endfunction

    function automatic logic [XLEN-1:0] rand_l();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; req_valid_i = 0; req_first_i = 0; req_clr_i = 0;
        req_l_i = '0; abort_i = 0; done_ready_i = 0;
        ref_l = '0;
        repeat (2) @(negedge clk_i);
        #1;
        total++;
        if (strobes() !== 7'b1000000 || round_o !== '0 || l_o !== '0) begin
            bad++;
            $display("FAIL reset: strobes=%b round=%0d l=%h, want 1000000/0/0", strobes(), round_o, l_o);
        end
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            done_ready_i = 1'($urandom);
            #1;
            total++;
            if (strobes() !== 7'b1000000 || round_o !== '0) begin
                bad++;
                $display("FAIL idle%0d: strobes=%b round=%0d, want 1000000/0", i, strobes(), round_o);
            end
        end
        @(negedge clk_i);
        done_ready_i = 0;
    endtask

    // Runs one block from the load cycle through `hold` un-acknowledged result cycles.
    // Entered and left just after a falling edge; b2b means the DUT is in DONE and this load is the ack cycle.
    task automatic run_block(input bit first, input bit clr, input logic [XLEN-1:0] l,
                             input int hold, input bit b2b);
        logic [XLEN-1:0] exp_l;
        req_valid_i = 1; req_first_i = first; req_clr_i = clr; req_l_i = l; done_ready_i = b2b;
        exp_l = first ? l : ref_l;
        #1;
        total++;
        if (strobes() !== {1'b1, 1'b1, first, 1'b0, 1'b0, 1'b0, b2b} || l_o !== exp_l) begin
            bad++;
            $display("FAIL load: strobes=%b l=%h, want %b l=%h", strobes(), l_o,
                     {1'b1, 1'b1, first, 4'b0, b2b}, exp_l);
        end
        if (b2b) begin
            total++;
            if (cyc != next_fire_cyc) begin
                bad++;
                $display("FAIL b2b_period: fire at cycle %0d, want %0d", cyc, next_fire_cyc);
            end
        end
        if (first) ref_l = l;
        next_fire_cyc = cyc + 1 + NR + hold;
        for (int k = 1; k <= int'(NR); k++) begin
            @(negedge clk_i);
            req_valid_i = 1'($urandom); req_first_i = 1'($urandom); req_clr_i = 1'($urandom);
            req_l_i = rand_l(); done_ready_i = 1'($urandom);
            #1;
            total++;
            if (strobes() !== {4'b0001, clr, 2'b10} || round_o !== RW'(k - 1) || l_o !== ref_l) begin
                bad++;
                $display("FAIL work%0d: strobes=%b round=%0d l=%h, want %b round=%0d l=%h", k,
                         strobes(), round_o, l_o, {4'b0001, clr, 2'b10}, k - 1, ref_l);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            done_ready_i = 0; req_valid_i = 1'($urandom); req_first_i = 1'($urandom);
            req_l_i = rand_l();
            #1;
            total++;
            if (strobes() !== 7'b0000001 || l_o !== ref_l) begin
                bad++;
                $display("FAIL hold%0d: strobes=%b l=%h, want 0000001 l=%h", h, strobes(), l_o, ref_l);
            end
        end
        @(negedge clk_i);
        req_valid_i = 0; done_ready_i = 0;
    endtask

    task automatic release_done();
        req_valid_i = 0; done_ready_i = 1;
        #1;
        total++;
        if (strobes() !== 7'b1000001) begin
            bad++;
            $display("FAIL release: strobes=%b, want 1000001", strobes());
        end
        @(negedge clk_i);
        done_ready_i = 0;
        #1;
        total++;
        if (strobes() !== 7'b1000000 || l_o !== ref_l) begin
            bad++;
            $display("FAIL after_release: strobes=%b l=%h, want 1000000 l=%h", strobes(), l_o, ref_l);
        end
    endtask

    task automatic test_first_block();
        run_block(1'b1, 1'b1, XLEN'(256), 0, 1'b0);
        release_done();
        @(negedge clk_i);
    endtask

    task automatic test_second_block();
        run_block(1'b0, 1'b0, XLEN'(8'h5A), 1, 1'b0);
        total++;
        if (ref_l !== XLEN'(256) || l_o !== XLEN'(256)) begin
            bad++;
            $display("FAIL second_l: l=%h, want %h", l_o, XLEN'(256));
        end
        release_done();
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        run_block(1'b1, 1'b0, rand_l(), 0, 1'b0);
        run_block(1'b0, 1'b1, rand_l(), 0, 1'b1);
        run_block(1'b1, 1'b0, rand_l(), 2, 1'b1);
        release_done();
        @(negedge clk_i);
    endtask

    task automatic test_backpressure();
        run_block(1'b0, 1'b1, rand_l(), 50, 1'b0);
        release_done();
        @(negedge clk_i);
    endtask

    // Interrupt a block at round `at` either by abort (sync) or by reset (async)
    task automatic test_abort(input bit use_reset, input int at);
        logic [XLEN-1:0] l = rand_l();
        req_valid_i = 1; req_first_i = 1; req_clr_i = 0; req_l_i = l;
        @(negedge clk_i);
        ref_l = l;
        req_valid_i = 0;
        repeat (at) @(negedge clk_i);
        #1;
        total++;
        if (work_o !== 1'b1 || round_o !== RW'(at)) begin
            bad++;
            $display("FAIL pre_abort: work=%b round=%0d, want 1/%0d", work_o, round_o, at);
        end
        if (use_reset) begin
            rst_ni = 0;
            ref_l = '0;
            #1;
            total++;
            if (strobes() !== 7'b1000000 || round_o !== '0 || l_o !== '0) begin
                bad++;
                $display("FAIL rst_mid: strobes=%b round=%0d l=%h, want 1000000/0/0", strobes(), round_o, l_o);
            end
            @(negedge clk_i);
            rst_ni = 1;
        end else begin
            abort_i = 1; req_valid_i = 1; req_first_i = 1; req_l_i = rand_l();
            #1;
            total++;
            if (req_ready_o !== 1'b0 || start_o !== 1'b0 || prep_o !== 1'b0 || l_o !== ref_l) begin
                bad++;
                $display("FAIL abort_cycle: ready=%b start=%b prep=%b l=%h, want 0/0/0 l=%h",
                         req_ready_o, start_o, prep_o, l_o, ref_l);
            end
            @(negedge clk_i);
            abort_i = 0; req_valid_i = 0;
        end
        for (int i = 0; i < 30; i++) begin
            #1;
            total++;
            if (strobes() !== 7'b1000000 || round_o !== '0 || l_o !== ref_l) begin
                bad++;
                $display("FAIL post_abort%0d: strobes=%b round=%0d l=%h, want 1000000/0 l=%h",
                         i, strobes(), round_o, l_o, ref_l);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_random();
        bit in_done = 0;
        bit b2b;
        for (int i = 0; i < 8; i++) begin
            b2b = in_done && 1'($urandom);
            if (in_done && !b2b) begin
                release_done();
                @(negedge clk_i);
            end
            run_block((i == 0) ? 1'b1 : 1'($urandom), 1'($urandom), rand_l(),
                      int'($urandom_range(0, 4)), b2b);
            in_done = 1;
        end
        release_done();
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_first_block();
        test_second_block();
        test_back_to_back();
        test_backpressure();
        test_abort(1'b0, 10);
        test_abort(1'b1, 5);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
